vector_store_serializer: RTL and testbench



---
 rtl/vector_pkg.sv | 17 +
 rtl/vector_store_serializer_lane_picker.sv | 25 ++
 rtl/vector_store_serializer.sv | 102 ++++++++++
 tb/tb_vector_store_serializer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector store serializer.
package vector_pkg;

    localparam int unsigned DEF_LANES   = 4;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_RADDR_W = 5;
    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned LANE_BYTES  = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        CAPTURE,
        SEND
    } state_t;

endpackage

// File: rtl/vector_store_serializer_lane_picker.sv
// Priority encoder: lowest pending lane and whether it is the final pending lane.
module lane_picker #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [LANES-1:0] mask,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    logic [LANES-1:0] rest;

    always_comb begin
        idx = '0;
        // Scan downward so the lowest set bit is the final assignment.
        for (int unsigned i = LANES; i > 0; i--) begin
            if (mask[i-1]) begin
                idx = IDX_W'(i - 1);
            end
        end
        rest = mask & ~(LANES'(1) << idx);
        last = (rest == '0);
    end

endmodule

// File: rtl/vector_store_serializer.sv
// Serializes one vector register into per-lane word store beats under a lane mask.
module vector_store_serializer
    import vector_pkg::*;
#(
    parameter int unsigned LANES   = DEF_LANES,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned RADDR_W = DEF_RADDR_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic [RADDR_W-1:0]           req_reg,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [LANES-1:0]             req_mask,
    output logic [RADDR_W-1:0]           rf_read_addr,
    input  logic [LANES-1:0][DATA_W-1:0] rf_read_data,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_data,
    output logic                         mem_last,
    output logic                         done
);

    localparam int unsigned IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    state_t                         state, state_nx;
    logic [RADDR_W-1:0]             reg_q;
    logic [ADDR_W-1:0]              base_q;
    logic [LANES-1:0]               pend_q;
    logic [LANES-1:0][DATA_W-1:0]   data_q;
    logic                           done_q;
    logic [IDX_W-1:0]               lane;
    logic                           lane_last;

    lane_picker #(
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_picker (
        .mask (pend_q),
        .idx  (lane),
        .last (lane_last)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_valid) state_nx = READ;
            READ:    state_nx = CAPTURE;
            CAPTURE: state_nx = (pend_q == '0) ? IDLE : SEND;
            SEND:    if (mem_ready && lane_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            reg_q  <= '0;
            base_q <= '0;
            pend_q <= '0;
            data_q <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        reg_q  <= req_reg;
                        base_q <= req_addr & ~ADDR_W'(3);
                        pend_q <= req_mask;
                    end
                end
                CAPTURE: begin
                    data_q <= rf_read_data;
                    if (pend_q == '0) done_q <= 1'b1;
                end
                SEND: begin
                    if (mem_ready) begin
                        pend_q <= pend_q & ~(LANES'(1) << lane);
                        if (lane_last) done_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Beat outputs derive from the pending mask, which only moves on a transfer,
    // so they hold steady through any stall.
    assign req_ready    = (state == IDLE);
    assign rf_read_addr = (state == IDLE) ? '0 : reg_q;
    assign mem_valid    = (state == SEND);
    assign mem_addr     = base_q + ADDR_W'(lane) * ADDR_W'(LANE_BYTES);
    assign mem_data     = data_q[lane];
    assign mem_last     = (state == SEND) && lane_last;
    assign done         = done_q;

endmodule

// File: tb/tb_vector_store_serializer.sv
// Randomized self-checking bench with a lane-list reference model of each store.
module tb_vector_store_serializer;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [4:0]       req_reg;
    logic [31:0]      req_addr;
    logic [3:0]       req_mask;
    logic [4:0]       rf_read_addr;
    logic [3:0][31:0] rf_read_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_data;
    logic             mem_last;
    logic             done;

    logic [3:0][31:0] rf [32];

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rf_read_data <= rf[rf_read_addr];

    vector_store_serializer #(
        .LANES   (4),
        .DATA_W  (32),
        .RADDR_W (5),
        .ADDR_W  (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_reg      (req_reg),
        .req_addr     (req_addr),
        .req_mask     (req_mask),
        .rf_read_addr (rf_read_addr),
        .rf_read_data (rf_read_data),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_data     (mem_data),
        .mem_last     (mem_last),
        .done         (done)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    endtask

    // Issues one store from an IDLE negedge and follows it to its done pulse.
    // abort_at >= 0 asserts rst once that many beats have transferred.
    task automatic do_store(input logic [4:0] r, input logic [31:0] a, input logic [3:0] m,
                            input int unsigned pct, input int abort_at);
        logic [31:0] q_addr[$];
        logic [31:0] q_data[$];
        logic        q_last[$];
        logic [31:0] base, p_addr, p_data;
        logic        p_last, stalled, fin;
        int          hi, cyc, done_cyc, sent;

        base = a & 32'hFFFF_FFFC;
        hi = -1;
        for (int l = 0; l < 4; l++) if (m[l]) hi = l;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) begin
                q_addr.push_back(base + 32'(4 * l));
                q_data.push_back(rf[r][l]);
                q_last.push_back(l == hi);
            end
        end

        check_eq("accept_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_reg   = r;
        req_addr  = a;
        req_mask  = m;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_reg   = 5'($urandom);
        req_addr  = $urandom;
        req_mask  = 4'($urandom);

        cyc = 0;
        done_cyc = (q_addr.size() == 0) ? 3 : -1;
        sent = 0;
        stalled = 1'b0;
        p_addr = '0; p_data = '0; p_last = 1'b0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            cyc++;
            check_eq("mem_valid", {63'd0, mem_valid}, {63'd0, (cyc >= 3 && q_addr.size() > 0)});
            check_eq("done", {63'd0, done}, {63'd0, (cyc == done_cyc)});
            check_eq("req_ready", {63'd0, req_ready}, {63'd0, (cyc == done_cyc)});
            check_eq("rf_read_addr", {59'd0, rf_read_addr}, (cyc == done_cyc) ? 64'd0 : {59'd0, r});
            if (mem_valid && q_addr.size() > 0) begin
                check_eq("mem_addr", {32'd0, mem_addr}, {32'd0, q_addr[0]});
                check_eq("mem_data", {32'd0, mem_data}, {32'd0, q_data[0]});
                check_eq("mem_last", {63'd0, mem_last}, {63'd0, q_last[0]});
                if (stalled) begin
                    check_eq("stall_addr", {32'd0, mem_addr}, {32'd0, p_addr});
                    check_eq("stall_data", {32'd0, mem_data}, {32'd0, p_data});
                    check_eq("stall_last", {63'd0, mem_last}, {63'd0, p_last});
                end
            end
            if (cyc == 3) rf[r] = {$urandom, $urandom, $urandom, $urandom};

            if (abort_at >= 0 && sent == abort_at) begin
                rst = 1'b1;
                mem_ready = 1'b1;
                req_valid = 1'b1;
                @(negedge clk);
                req_valid = 1'b0;
                rst = 1'b0;
                check_eq("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
                check_eq("rst_mem_last", {63'd0, mem_last}, 64'd0);
                check_eq("rst_done", {63'd0, done}, 64'd0);
                check_eq("rst_req_ready", {63'd0, req_ready}, 64'd1);
                check_eq("rst_rf_addr", {59'd0, rf_read_addr}, 64'd0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check_eq("post_rst_done", {63'd0, done}, 64'd0);
                    check_eq("post_rst_valid", {63'd0, mem_valid}, 64'd0);
                end
                return;
            end

            mem_ready = (pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct);
            stalled = mem_valid && !mem_ready;
            p_addr = mem_addr; p_data = mem_data; p_last = mem_last;
            if (mem_valid && mem_ready && q_addr.size() > 0) begin
                void'(q_addr.pop_front());
                void'(q_data.pop_front());
                void'(q_last.pop_front());
                sent++;
                if (q_addr.size() == 0) done_cyc = cyc + 1;
            end
            if (cyc == done_cyc) fin = 1'b1;
            if (cyc > 400) begin
                check_eq("timeout", 64'd1, 64'd0);
                fin = 1'b1;
            end
        end
        if (pct >= 100) check_eq("latency", 64'(cyc), 64'(3 + $countones(m)));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = {$urandom, $urandom, $urandom, $urandom};
        rf[3] = {32'h44, 32'h33, 32'h22, 32'h11};
        rst = 1'b1;
        req_valid = 1'b0;
        req_reg = '0;
        req_addr = '0;
        req_mask = '0;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("reset_ready", {63'd0, req_ready}, 64'd1);
        check_eq("reset_valid", {63'd0, mem_valid}, 64'd0);
        check_eq("reset_last", {63'd0, mem_last}, 64'd0);
        check_eq("reset_done", {63'd0, done}, 64'd0);
        check_eq("reset_rf_addr", {59'd0, rf_read_addr}, 64'd0);
        @(negedge clk);

        do_store(5'd3, 32'h0000_1000, 4'b1111, 100, -1);
        do_store(5'd7, 32'h0000_2002, 4'b1010, 100, -1);
        do_store(5'd9, 32'h0000_3000, 4'b0000, 100, -1);
        do_store(5'd1, 32'hFFFF_FFF8, 4'b1111, 100, -1);
        do_store(5'd4, 32'h0000_4000, 4'b1111, 50, -1);
        do_store(5'd5, 32'h0000_5000, 4'b1111, 100, 2);
        do_store(5'd6, 32'h0000_6000, 4'b0110, 100, -1);

        for (int t = 0; t < 25; t++) begin
            do_store(5'($urandom), $urandom, 4'($urandom), $urandom_range(0, 2) * 35 + 30, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
